// File: rtl/aes128_key_expand_if.sv
// aes128_key_expand_if: start/key request, status and round-key read port of the key schedule engine
interface aes128_key_expand_if;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         ready;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  modport master (output start, key, rd_round, input busy, ready, rd_key);
  modport slave  (input start, key, rd_round, output busy, ready, rd_key);
endinterface

// File: rtl/aes128_key_expand.sv
// aes128_key_expand: iterative AES-128 key schedule, one round key per clock into an 11-entry register file
module aes128_key_expand (
  input logic             clk,
  input logic             rst,
  aes128_key_expand_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:15][7:0] RCON = {
    64'h0001020408102040, 64'h801b360000000000};
  state_t       state_q, state_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];
  logic [127:0] prev;
  logic [31:0]  t, n0, n1, n2, n3;
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
  always_comb begin
    prev = rk_q[rc_q - 4'd1];
    t  = sub_word({prev[23:0], prev[31:24]}) ^ {RCON[rc_q], 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    state_d = state_q;
    rc_d    = rc_q;
    rk_d    = rk_q;
    if (state_q == EXPAND) begin
      rk_d[rc_q] = {n0, n1, n2, n3};
      rc_d       = rc_q + 4'd1;
      state_d    = rc_q == 4'd10 ? DONE : EXPAND;
    end else if (bus.start) begin
      rk_d[0] = bus.key;
      rc_d    = 4'd1;
      state_d = EXPAND;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      rk_q    <= rk_d;
    end
  end
  assign bus.busy   = state_q == EXPAND;
  assign bus.ready  = state_q == DONE;
  assign bus.rd_key = bus.rd_round > 4'd10 ? '0 : rk_q[bus.rd_round];
endmodule

// File: doc/aes128_key_expand.md
# aes128_key_expand

Iterative AES-128 key schedule engine that sits directly upstream of the round datapath. It accepts a 128-bit cipher key, computes round keys 0–10 at one per clock per FIPS-197, and holds them in an internal register file. The round datapath reads any round key by index through a combinational read port, so it no longer derives keys on the fly. Once loaded, the engine serves any number of blocks under the same key.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- CLOCK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request to expand KEY; sampled on the rising edge.
- KEY  in  128  cipher key; KEY[127:120] is byte 0, word w0 = KEY[127:96].
- BUSY  out  1  high while expansion is in progress.
- READY  out  1  high when all 11 round keys are valid.
- RD_ROUND  in  4  round-key index, 0..10.
- RD_KEY  out  128  round key RD_ROUND, same byte order as KEY; combinational from the register file.

## Operation
- Storage:
  - 11×128-bit round-key registers rk[0..10].
  - 4-bit round counter rc.
  - 2-bit FSM with states IDLE, EXPAND, DONE.
- S-box: internal 256-entry forward S-box, four combinational instances for SubWord. No shared tables.
- Rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36, in byte 0 of the word.
- Expansion for round r (1..10), with prev = rk[r-1] split into words p0..p3:
  - t = SubWord(RotWord(p3)) ^ {Rcon[r],00,00,00}, where RotWord turns bytes a,b,c,d into b,c,d,a.
  - n0 = p0^t; n1 = p1^n0; n2 = p2^n1; n3 = p3^n2.
  - rk[r] = {n0,n1,n2,n3}.
- FSM transitions:
  - IDLE: START=1 → rk[0] ← KEY, rc ← 1, go to EXPAND.
  - EXPAND: rk[rc] ← expand(rk[rc-1]), rc ← rc+1. When rc=10 is written, go to DONE.
  - DONE: hold all keys. START=1 → rk[0] ← KEY, rc ← 1, go to EXPAND.
- START while in EXPAND is ignored. No queuing, and the current expansion completes unaffected.
- KEY is sampled only on the accepting edge. Later changes to KEY have no effect.
- RD_ROUND > 10 returns RD_KEY = 0.
- RD_KEY is valid for a given index only while READY=1. Outside READY it shows whatever the register currently holds, and consumers must not use it.

## Timing
- Reset, at the edge with RESET=1, regardless of state or START:
  - FSM ← IDLE, rc ← 0, BUSY ← 0, READY ← 0.
  - All rk ← 0.
  - RESET has priority over START on the same edge.
- Accept edge E (START=1 in IDLE or DONE): at E, BUSY ← 1 and READY ← 0.
- rk[r] is written at edge E+r, for r = 1..10.
- At E+10: BUSY ← 0 and READY ← 1.
- Latency from the START edge to READY high is 10 cycles. READY and BUSY are registered and never both high.
- Back-to-back: START on the edge where READY goes high is not possible, since FSM is still EXPAND before that edge. START on the next edge (E+11) is accepted, and READY drops at that edge.
- RESET during EXPAND aborts the expansion. The next START restarts cleanly from round 0.
- RD_KEY has zero cycle latency from RD_ROUND (pure mux).

## Test plan
- FIPS-197 key: KEY=2b7e151628aed2a6abf7158809cf4f3c, START for 1 cycle.
  - READY rises exactly 10 cycles after the START edge, with BUSY high for those 10 cycles.
  - RD_ROUND=1 → a0fafe1788542cb123a339392a6c7605.
  - RD_ROUND=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - RD_ROUND=0 → the key itself.
- All-zero key:
  - RD_ROUND=1 → 62636363626363636263636362636363.
  - RD_ROUND=10 → b4ef5bcb3e92e21123e951cf6f8f188e.
- Ignored START: pulse START for the FIPS key, then pulse START with the zero key 3 cycles later.
  - The second START is ignored.
  - READY timing is unchanged from the first START.
  - The round-10 key matches the FIPS key.
- Reset mid-expansion: assert RESET 5 cycles into expansion.
  - The next cycle shows BUSY=0, READY=0, and RD_KEY=0 for all indices.
  - A fresh START produces correct keys after 10 cycles.
- Re-key from DONE: after READY, START with the zero key.
  - READY drops on that edge and returns 10 cycles later.
  - Round-10 key = b4ef5bcb3e92e21123e951cf6f8f188e.
- Out-of-range reads: RD_ROUND=11..15 with READY=1 → RD_KEY=0.
- RESET and START asserted on the same edge → stays IDLE, with READY=0 and BUSY=0.
